// File: rtl/factory_test_sequencer.sv
// Bring-up sequencer for board test: two debounced keys step through loopback,
// counter, walking-one and bidirectional pass-through output patterns.
module factory_test_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] key_in,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [2:0] mode_o
);

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_LOOP  = 3'd1;
    localparam logic [2:0] MODE_COUNT = 3'd2;
    localparam logic [2:0] MODE_WALK  = 3'd3;
    localparam logic [2:0] MODE_BIDIR = 3'd4;

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PW = $clog2(PRESCALE);

    logic [1:0] key_level;
    logic       unused_keys;

    assign unused_keys = ^key_in[7:2];

    // Per key: two-flop synchronizer followed by a consecutive-cycle debouncer.
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic          sync_a_reg;
        logic          sync_b_reg;
        logic          level_reg;
        logic [DW-1:0] cnt_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_a_reg <= 1'b0;
                sync_b_reg <= 1'b0;
                level_reg  <= 1'b0;
                cnt_reg    <= '0;
            end else begin
                sync_a_reg <= key_in[gi];
                sync_b_reg <= sync_a_reg;
                if (sync_b_reg != level_reg) begin
                    if (cnt_reg == DW'(DEBOUNCE - 1)) begin
                        level_reg <= sync_b_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign key_level[gi] = level_reg;
    end

    logic          adv_prev_reg;
    logic          advance;
    logic          freeze;
    logic [2:0]    mode_reg;
    logic [2:0]    mode_next;
    logic          mode_change;
    logic [PW-1:0] presc_reg;
    logic          tick;
    logic [7:0]    counter_reg;
    logic [7:0]    walker_reg;
    logic [7:0]    walker_rev;

    assign advance     = key_level[0] & ~adv_prev_reg;
    assign freeze      = key_level[1];
    assign tick        = (presc_reg == PW'(PRESCALE - 1));
    assign mode_change = (mode_next != mode_reg);
    assign mode_o      = mode_reg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign walker_rev[gi] = walker_reg[7-gi];
    end

    // ena low wins over everything, including an advance pulse in the same cycle.
    always_comb begin
        mode_next = mode_reg;
        if (!ena) begin
            mode_next = MODE_IDLE;
        end else begin
            case (mode_reg)
                MODE_IDLE:  mode_next = MODE_LOOP;
                MODE_LOOP:  if (advance) mode_next = MODE_COUNT;
                MODE_COUNT: if (advance) mode_next = MODE_WALK;
                MODE_WALK:  if (advance) mode_next = MODE_BIDIR;
                MODE_BIDIR: if (advance) mode_next = MODE_LOOP;
                default:    mode_next = MODE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg     <= MODE_IDLE;
            adv_prev_reg <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            adv_prev_reg <= key_level[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg   <= '0;
            counter_reg <= 8'h00;
            walker_reg  <= 8'h01;
        end else if (mode_change) begin
            presc_reg <= '0;
            if (mode_next == MODE_COUNT) counter_reg <= 8'h00;
            if (mode_next == MODE_WALK)  walker_reg  <= 8'h01;
        end else if (!freeze) begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick && mode_reg == MODE_COUNT) counter_reg <= counter_reg + 8'd1;
            if (tick && mode_reg == MODE_WALK)  walker_reg  <= {walker_reg[6:0], walker_reg[7]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_out  <= 8'h00;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
        end else begin
            case (mode_reg)
                MODE_LOOP: begin
                    uo_out  <= ui_in;
                    uio_out <= ~ui_in;
                    uio_oe  <= 8'hFF;
                end
                MODE_COUNT: begin
                    uo_out  <= counter_reg;
                    uio_out <= counter_reg;
                    uio_oe  <= 8'hFF;
                end
                MODE_WALK: begin
                    uo_out  <= walker_reg;
                    uio_out <= walker_rev;
                    uio_oe  <= 8'hFF;
                end
                MODE_BIDIR: begin
                    uo_out  <= uio_in;
                    uio_out <= 8'h00;
                    uio_oe  <= 8'h00;
                end
                default: begin
                    uo_out  <= 8'h00;
                    uio_out <= 8'h00;
                    uio_oe  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factory_test_sequencer.sv
// Randomized bench for factory_test_sequencer against a history-based reference model.
module tb_factory_test_sequencer;

    localparam int D = 4;
    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] key_in;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [2:0] mode_o;

    factory_test_sequencer #(.DEBOUNCE(D), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .ena(ena), .key_in(key_in), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_io = 0;

    // Reference model: raw key history, mode number, unfrozen cycles since mode entry.
    bit       hist0[$];
    bit       hist1[$];
    bit [1:0] m_lvl;
    bit       m_rise;
    int       m_mode;
    int       m_n;
    bit [7:0] e_uo, e_uio, e_oe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [7:0] rev8(input bit [7:0] v);
        bit [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // True when the last D synchronized samples all disagree with the level.
    function automatic bit settle(input bit q[$], input bit lvl);
        bit all_diff = 1;
        for (int j = 1; j <= D; j++)
            if (q[q.size()-1-j] == lvl) all_diff = 0;
        return all_diff;
    endfunction

    task automatic model_reset();
        hist0 = {};
        hist1 = {};
        for (int i = 0; i < D + 2; i++) begin
            hist0.push_back(1'b0);
            hist1.push_back(1'b0);
        end
        m_lvl = 2'b00; m_rise = 0; m_mode = 0; m_n = 0;
        e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00;
    endtask

    task automatic model_edge();
        bit       adv = m_rise;
        bit       frz = m_lvl[1];
        bit       old0 = m_lvl[0];
        int       nxt;
        bit [7:0] c;
        case (m_mode)
            1: begin e_uo = ui_in; e_uio = ~ui_in; e_oe = 8'hFF; end
            2: begin c = 8'((m_n / P) % 256); e_uo = c; e_uio = c; e_oe = 8'hFF; end
            3: begin c = 8'h01 << ((m_n / P) % 8); e_uo = c; e_uio = rev8(c); e_oe = 8'hFF; end
            4: begin e_uo = uio_in; e_uio = 8'h00; e_oe = 8'h00; end
            default: begin e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00; end
        endcase
        if (!ena)             nxt = 0;
        else if (m_mode == 0) nxt = 1;
        else if (adv)         nxt = (m_mode == 4) ? 1 : m_mode + 1;
        else                  nxt = m_mode;
        if (nxt != m_mode) m_n = 0;
        else if (!frz)     m_n++;
        m_mode = nxt;
        if (settle(hist0, m_lvl[0])) m_lvl[0] = ~m_lvl[0];
        if (settle(hist1, m_lvl[1])) m_lvl[1] = ~m_lvl[1];
        m_rise = !old0 && m_lvl[0];
        hist0.push_back(key_in[0]); void'(hist0.pop_front());
        hist1.push_back(key_in[1]); void'(hist1.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check("mode", 32'(mode_o), 32'(m_mode));
        check("uo", 32'(uo_out), 32'(e_uo));
        check("uio", 32'(uio_out), 32'(e_uio));
        check("oe", 32'(uio_oe), 32'(e_oe));
        if (rand_io) begin
            ui_in       = 8'($urandom);
            key_in[7:2] = 6'($urandom);
        end
    endtask

    task automatic press_advance();
        key_in[0] = 1'b1;
        repeat (D + 6) step();
        key_in[0] = 1'b0;
        repeat (D + 4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int       edges, steps, bad, chg, idx, run0, run1;
        bit [7:0] prev, held, w;

        rst = 1'b1; ena = 1'b0; key_in = 8'h00; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        @(negedge clk);
        repeat (3) step();
        check("rst_mode", 32'(mode_o), 32'd0);
        check("rst_uo", 32'(uo_out), 32'h00);
        check("rst_oe", 32'(uio_oe), 32'h00);

        // Loopback straight out of reset.
        ena = 1'b1; ui_in = 8'hA5; rst = 1'b0;
        step();
        check("loop_mode", 32'(mode_o), 32'd1);
        step();
        check("loop_uo", 32'(uo_out), 32'hA5);
        check("loop_uio", 32'(uio_out), 32'h5A);
        check("loop_oe", 32'(uio_oe), 32'hFF);

        // Short bounces must not advance.
        rand_io = 1;
        for (int b = 0; b < 5; b++) begin
            key_in[0] = 1'b1;
            repeat (D - 1) step();
            key_in[0] = 1'b0;
            repeat (1 + $urandom_range(0, 3)) step();
        end
        check("bounce_mode", 32'(mode_o), 32'd1);

        key_in[0] = 1'b1;
        edges = 0;
        while (mode_o == 3'd1 && edges < 100) begin
            step();
            edges++;
        end
        check("adv_latency", 32'(edges), 32'(D + 3));
        check("count_mode", 32'(mode_o), 32'd2);

        // Full counter cycle, key 0 held for 50 cycles in total.
        step();
        check("count_start", 32'(uo_out), 32'h00);
        prev = uo_out; steps = 0; bad = 0;
        for (int i = 0; i < 256 * P; i++) begin
            key_in[0] = (edges + 1 + i < 50);
            step();
            if (uo_out != prev) begin
                steps++;
                if (uo_out != 8'(prev + 8'd1)) bad++;
                prev = uo_out;
            end
        end
        check("count_steps", 32'(steps), 32'd256);
        check("count_bad", 32'(bad), 32'd0);
        check("count_wrap", 32'(uo_out), 32'h00);
        check("one_advance", 32'(mode_o), 32'd2);

        // Freeze holds the counter, release resumes it.
        key_in[1] = 1'b1;
        repeat (D + 4) step();
        held = uo_out; chg = 0;
        repeat (100) begin
            step();
            if (uo_out != held) chg++;
        end
        check("freeze_hold", 32'(chg), 32'd0);
        key_in[1] = 1'b0;
        repeat (D + 4 + 3 * P) step();
        check("freeze_resume", 32'(uo_out != held), 32'd1);

        // Walking one for nine ticks.
        press_advance();
        check("walk_mode", 32'(mode_o), 32'd3);
        check("walk_start", 32'(uo_out), 32'h01);
        check("walk_start_rev", 32'(uio_out), 32'h80);
        prev = uo_out; idx = 0;
        for (int i = 0; i < 9 * P + 2; i++) begin
            step();
            if (uo_out != prev) begin
                idx++;
                w = 8'h01 << (idx % 8);
                check("walk_uo", 32'(uo_out), 32'(w));
                check("walk_uio", 32'(uio_out), 32'(rev8(w)));
                prev = uo_out;
            end
        end
        check("walk_ticks", 32'(idx), 32'd9);

        // Bidirectional pass-through, then ena drop coinciding with an advance pulse.
        uio_in = 8'h3C;
        press_advance();
        check("bidir_mode", 32'(mode_o), 32'd4);
        check("bidir_uo", 32'(uo_out), 32'h3C);
        check("bidir_oe", 32'(uio_oe), 32'h00);
        check("bidir_uio", 32'(uio_out), 32'h00);
        key_in[0] = 1'b1;
        repeat (D + 2) step();
        ena = 1'b0;
        step();
        check("ena_prio_mode", 32'(mode_o), 32'd0);
        step();
        check("idle_uo", 32'(uo_out), 32'h00);
        check("idle_oe", 32'(uio_oe), 32'h00);
        ena = 1'b1;
        step();
        check("reenable_mode", 32'(mode_o), 32'd1);
        key_in[0] = 1'b0;
        repeat (D + 4) step();

        // Reset during a pending debounce.
        key_in[0] = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst", 32'(mode_o), 32'd0);
        step();
        key_in[0] = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("rst_recover", 32'(mode_o), 32'd1);
        repeat (D + 4) step();
        check("rst_no_adv", 32'(mode_o), 32'd1);

        // Random soak against the model.
        run0 = 0; run1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run0 == 0) begin
                key_in[0] = ~key_in[0];
                run0 = $urandom_range(1, 2 * D + 2);
            end
            if (run1 == 0) begin
                key_in[1] = ~key_in[1];
                run1 = $urandom_range(1, 3 * D);
            end
            run0--; run1--;
            ena    = ($urandom_range(0, 99) != 0);
            uio_in = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
